// File: rtl/mips_pkg.sv
// Shared definitions for the mips bus memory responder: word width, I/O address, loader states.
package mips_pkg;
  localparam int          DW      = 16;
  localparam logic [15:0] IO_ADDR = 16'hFFFF;

  typedef enum logic [1:0] {
    LD_IDLE = 2'd0,
    LD_HI   = 2'd1,
    LD_LO   = 2'd2,
    LD_WR   = 2'd3
  } ld_state_e;
endpackage

// File: rtl/mips_byte_loader.sv
// Byte-serial program loader: assembles high/low byte pairs into words and
// writes them to sequential RAM addresses while holding the CPU.
module mips_byte_loader #(
  parameter int DW = mips_pkg::DW,
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load_mode,
  input  logic          load_valid,
  input  logic [7:0]    load_byte,
  output logic          load_ready,
  output logic          cpu_hold,
  output logic [AW-1:0] load_count,
  output logic          load_overflow,
  output logic          we,
  output logic [AW-1:0] waddr,
  output logic [DW-1:0] wdata
);
  import mips_pkg::*;

  ld_state_e r_state, w_state_nxt;
  logic [7:0] r_hi, r_lo;
  logic       w_take;

  assign w_take   = load_valid & load_ready;
  assign cpu_hold = (r_state != LD_IDLE);
  assign waddr    = load_count;
  assign wdata    = DW'({r_hi, r_lo});

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= LD_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Dropping load_mode abandons a partial word, but a word already in LD_WR commits.
  always_comb begin
    w_state_nxt = r_state;
    load_ready  = 1'b0;
    we          = 1'b0;
    case (r_state)
      LD_IDLE: if (load_mode) w_state_nxt = LD_HI;
      LD_HI: begin
        load_ready = 1'b1;
        if (!load_mode)      w_state_nxt = LD_IDLE;
        else if (load_valid) w_state_nxt = LD_LO;
      end
      LD_LO: begin
        load_ready = 1'b1;
        if (!load_mode)      w_state_nxt = LD_IDLE;
        else if (load_valid) w_state_nxt = LD_WR;
      end
      LD_WR: begin
        we          = 1'b1;
        w_state_nxt = load_mode ? LD_HI : LD_IDLE;
      end
      default: w_state_nxt = LD_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      load_count    <= '0;
      load_overflow <= 1'b0;
      r_hi          <= '0;
      r_lo          <= '0;
    end else begin
      case (r_state)
        LD_IDLE: if (load_mode) begin
          load_count    <= '0;
          load_overflow <= 1'b0;
        end
        LD_HI: if (load_mode && w_take) r_hi <= load_byte;
        LD_LO: if (load_mode && w_take) r_lo <= load_byte;
        LD_WR: begin
          load_count <= load_count + 1'b1;
          if (&load_count) load_overflow <= 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: rtl/mips_mem_responder.sv
// Memory-side responder for the 16-bit multicycle CPU bus: unified word RAM,
// one memory-mapped I/O word, and a byte-serial loader that owns the RAM while active.
module mips_mem_responder #(
  parameter int          DW      = mips_pkg::DW,
  parameter int          AW      = 8,
  parameter logic [15:0] IO_ADDR = mips_pkg::IO_ADDR
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [15:0]   adr,
  input  logic [DW-1:0] writedata,
  input  logic          memwrite,
  output logic [DW-1:0] readdata,
  input  logic [DW-1:0] io_in,
  output logic [DW-1:0] io_out,
  input  logic          load_mode,
  input  logic          load_valid,
  input  logic [7:0]    load_byte,
  output logic          load_ready,
  output logic          cpu_hold,
  output logic [AW-1:0] load_count,
  output logic          load_overflow
);
  import mips_pkg::*;

  logic [DW-1:0] r_mem [0:(2**AW)-1];

  logic          w_ld_we;
  logic [AW-1:0] w_ld_waddr;
  logic [DW-1:0] w_ld_wdata;
  logic          w_is_io, w_cpu_we;
  logic          w_we;
  logic [AW-1:0] w_waddr;
  logic [DW-1:0] w_wdata;

  mips_byte_loader #(.DW(DW), .AW(AW)) u_loader (
    .clk           (clk),
    .reset         (reset),
    .load_mode     (load_mode),
    .load_valid    (load_valid),
    .load_byte     (load_byte),
    .load_ready    (load_ready),
    .cpu_hold      (cpu_hold),
    .load_count    (load_count),
    .load_overflow (load_overflow),
    .we            (w_ld_we),
    .waddr         (w_ld_waddr),
    .wdata         (w_ld_wdata)
  );

  // Upper address bits only matter for the I/O decode; RAM aliases across them.
  assign w_is_io  = (adr == IO_ADDR);
  assign w_cpu_we = memwrite & ~cpu_hold;
  assign readdata = w_is_io ? io_in : r_mem[adr[AW-1:0]];

  // The loader only writes while cpu_hold is high, so the two writers never collide.
  assign w_we    = w_ld_we | (w_cpu_we & ~w_is_io);
  assign w_waddr = w_ld_we ? w_ld_waddr : adr[AW-1:0];
  assign w_wdata = w_ld_we ? w_ld_wdata : writedata;

  always_ff @(posedge clk) begin
    if (w_we) r_mem[w_waddr] <= w_wdata;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                  io_out <= '0;
    else if (w_cpu_we && w_is_io) io_out <= writedata;
  end
endmodule

// File: tb/tb_mips_mem_responder.sv
// Directed bench for mips_mem_responder: CPU access table plus loader sequences
// on an AW=8 instance and an AW=2 instance for wrap/overflow.
module tb_mips_mem_responder;
  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] adr, writedata, readdata, io_in, io_out;
  logic        memwrite, load_mode, load_valid, load_ready, cpu_hold, load_overflow;
  logic [7:0]  load_byte, load_count;

  logic [15:0] adr2, rd2, io_out2;
  logic        lm2, lv2, lr2, hold2, ovf2;
  logic [7:0]  lb2;
  logic [1:0]  cnt2;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mips_mem_responder #(.AW(8)) dut (
    .clk(clk), .reset(reset), .adr(adr), .writedata(writedata), .memwrite(memwrite),
    .readdata(readdata), .io_in(io_in), .io_out(io_out), .load_mode(load_mode),
    .load_valid(load_valid), .load_byte(load_byte), .load_ready(load_ready),
    .cpu_hold(cpu_hold), .load_count(load_count), .load_overflow(load_overflow)
  );

  mips_mem_responder #(.AW(2)) dut2 (
    .clk(clk), .reset(reset), .adr(adr2), .writedata(16'h0000), .memwrite(1'b0),
    .readdata(rd2), .io_in(16'h0000), .io_out(io_out2), .load_mode(lm2),
    .load_valid(lv2), .load_byte(lb2), .load_ready(lr2),
    .cpu_hold(hold2), .load_count(cnt2), .load_overflow(ovf2)
  );

  typedef struct {
    logic [15:0] adr;
    logic [15:0] wd;
    logic        we;
    logic [15:0] ioin;
    logic        chk;
    logic [15:0] exp_rd;
    logic [15:0] exp_io;
  } vec_t;

  vec_t tbl [9];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic rd(input string name, input logic [15:0] a, input logic [15:0] exp);
    adr = a;
    #1 check(name, readdata, exp);
  endtask

  task automatic rd_2(input string name, input logic [15:0] a, input logic [15:0] exp);
    adr2 = a;
    #1 check(name, rd2, exp);
  endtask

  task automatic send_byte(input bit d2, input logic [7:0] b);
    int n;
    bit ok;
    n  = 0;
    ok = 1'b0;
    if (d2) begin lv2 = 1'b1; lb2 = b; end
    else    begin load_valid = 1'b1; load_byte = b; end
    while (!ok && n < 20) begin
      @(negedge clk);
      if (d2 ? lr2 : load_ready) ok = 1'b1;
      else n++;
    end
    if (!ok) begin
      n_tests++;
      n_fail++;
      $display("FAIL send_byte timeout: load_ready stayed 0, required 1");
    end
    @(posedge clk);
    #1;
    lv2 = 1'b0;
    load_valid = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    tbl[0] = '{16'h00FF, 16'h7777, 1'b1, 16'h0A0A, 1'b0, 16'h0000, 16'h0000};
    tbl[1] = '{16'h0005, 16'hBEEF, 1'b1, 16'h0A0A, 1'b0, 16'h0000, 16'h0000};
    tbl[2] = '{16'h0005, 16'h0000, 1'b0, 16'h0A0A, 1'b1, 16'hBEEF, 16'h0000};
    tbl[3] = '{16'hFFFF, 16'hBEEF, 1'b1, 16'h0A0A, 1'b1, 16'h0A0A, 16'h0000};
    tbl[4] = '{16'hFFFF, 16'h0000, 1'b0, 16'h1234, 1'b1, 16'h1234, 16'hBEEF};
    tbl[5] = '{16'h00FF, 16'h0000, 1'b0, 16'h0A0A, 1'b1, 16'h7777, 16'hBEEF};
    tbl[6] = '{16'h0003, 16'h1111, 1'b1, 16'h0000, 1'b0, 16'h0000, 16'hBEEF};
    tbl[7] = '{16'h0103, 16'h2222, 1'b1, 16'h0000, 1'b1, 16'h1111, 16'hBEEF};
    tbl[8] = '{16'h0003, 16'h0000, 1'b0, 16'h0000, 1'b1, 16'h2222, 16'hBEEF};

    reset = 1'b0; adr = '0; writedata = '0; memwrite = 1'b0; io_in = '0;
    load_mode = 1'b0; load_valid = 1'b0; load_byte = '0;
    adr2 = '0; lm2 = 1'b0; lv2 = 1'b0; lb2 = '0;
    #12;
    check("rst io_out", io_out, 16'h0000);
    check("rst cpu_hold", 16'(cpu_hold), 16'h0000);
    check("rst load_ready", 16'(load_ready), 16'h0000);
    check("rst load_count", 16'(load_count), 16'h0000);
    check("rst overflow", 16'(load_overflow), 16'h0000);
    tick();
    reset = 1'b1;

    // CPU access table: readdata sampled before the edge that commits the row's store.
    for (int i = 0; i < 9; i++) begin
      tick();
      adr = tbl[i].adr; writedata = tbl[i].wd; memwrite = tbl[i].we; io_in = tbl[i].ioin;
      @(negedge clk);
      if (tbl[i].chk) check($sformatf("tbl%0d readdata", i), readdata, tbl[i].exp_rd);
      check($sformatf("tbl%0d io_out", i), io_out, tbl[i].exp_io);
    end
    tick();
    memwrite = 1'b0;

    // Load two words.
    load_mode = 1'b1;
    send_byte(0, 8'h12); send_byte(0, 8'h34);
    send_byte(0, 8'h56); send_byte(0, 8'h78);
    tick();
    check("load2 count", 16'(load_count), 16'd2);
    check("load2 hold", 16'(cpu_hold), 16'd1);
    check("load2 ready in HI", 16'(load_ready), 16'd1);
    adr = 16'h0003; writedata = 16'hDEAD; memwrite = 1'b1;
    tick();
    memwrite = 1'b0;
    rd("held store dropped", 16'h0003, 16'h2222);
    rd("load2 mem0", 16'h0000, 16'h1234);
    rd("load2 mem1", 16'h0001, 16'h5678);
    load_mode = 1'b0;
    tick();
    check("load2 end hold", 16'(cpu_hold), 16'd0);
    check("load2 end count", 16'(load_count), 16'd2);
    check("load2 end ready", 16'(load_ready), 16'd0);

    // Abort after a single high byte.
    load_mode = 1'b1;
    tick();
    send_byte(0, 8'hAB);
    load_mode = 1'b0;
    tick();
    check("abort hold", 16'(cpu_hold), 16'd0);
    check("abort count", 16'(load_count), 16'd0);
    rd("abort mem0", 16'h0000, 16'h1234);
    rd("abort mem1", 16'h0001, 16'h5678);

    // Reset while in LD_LO with one word already loaded.
    load_mode = 1'b1;
    tick();
    send_byte(0, 8'h9A); send_byte(0, 8'hBC); send_byte(0, 8'hDE);
    check("pre-rst count", 16'(load_count), 16'd1);
    check("pre-rst hold", 16'(cpu_hold), 16'd1);
    reset = 1'b0;
    @(negedge clk);
    check("midrst hold", 16'(cpu_hold), 16'd0);
    check("midrst count", 16'(load_count), 16'd0);
    check("midrst io_out", io_out, 16'h0000);
    check("midrst ready", 16'(load_ready), 16'd0);
    rd("midrst mem0", 16'h0000, 16'h9ABC);
    rd("midrst mem1", 16'h0001, 16'h5678);
    load_mode = 1'b0;
    tick();
    reset = 1'b1;

    // AW=2 instance: five words wrap the four-word RAM.
    lm2 = 1'b1;
    tick();
    for (int w = 1; w <= 5; w++) begin
      send_byte(1, 8'(w * 8'h11));
      send_byte(1, 8'h00);
    end
    tick();
    check("wrap overflow", 16'(ovf2), 16'd1);
    check("wrap count", 16'(cnt2), 16'd1);
    rd_2("wrap mem0", 16'h0000, 16'h5500);
    rd_2("wrap mem1", 16'h0001, 16'h2200);
    rd_2("wrap mem3", 16'h0003, 16'h4400);
    lm2 = 1'b0;
    tick();
    check("wrap idle hold", 16'(hold2), 16'd0);
    lm2 = 1'b1;
    tick();
    check("reload ovf clear", 16'(ovf2), 16'd0);
    check("reload count clear", 16'(cnt2), 16'd0);
    lm2 = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
